// File: rtl/dmem_arbiter_if.sv
// Purpose : bundles the two requester ports and the data-memory port of dmem_arbiter.
// Latency : n/a (signal bundle only).
// Backpressure: requesters hold req (and its fields) until the matching gnt.
// Ports: p0_* pipeline MEM-stage port, p1_* DMA/debug port, mem_* single-port data memory.
// slave modport = arbiter side, master modport = requesters + memory side.
interface dmem_arbiter_if;
    // port 0 (pipeline MEM stage)
    logic        p0_req;
    logic        p0_we;
    logic [31:0] p0_addr;
    logic [31:0] p0_wdata;
    logic        p0_gnt;
    logic        p0_rvalid;
    logic [31:0] p0_rdata;
    logic        p0_err;
    // port 1 (DMA / debug)
    logic        p1_req;
    logic        p1_we;
    logic [31:0] p1_addr;
    logic [31:0] p1_wdata;
    logic        p1_gnt;
    logic        p1_rvalid;
    logic [31:0] p1_rdata;
    logic        p1_err;
    // data memory
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic        mem_write;
    logic [31:0] mem_rd;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        output p0_gnt, p0_rvalid, p0_rdata, p0_err,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        output p1_gnt, p1_rvalid, p1_rdata, p1_err,
        output mem_addr, mem_wd, mem_write,
        input  mem_rd
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        input  p0_gnt, p0_rvalid, p0_rdata, p0_err,
        output p1_req, p1_we, p1_addr, p1_wdata,
        input  p1_gnt, p1_rvalid, p1_rdata, p1_err,
        input  mem_addr, mem_wd, mem_write,
        output mem_rd
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Purpose : two-port arbiter in front of a single-port data memory, port 0 priority with
//           a starvation override for port 1, address legality check and conflict counter.
// Latency : grant is combinational in the request cycle; response (rvalid/rdata/err) one cycle later.
// Backpressure: a requester not granted simply keeps req high; one access per cycle throughput.
// Ports: clk, rst (async, active-high), bus (dmem_arbiter_if.slave), conflict_cnt (16-bit, saturating).
module dmem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned DEPTH_WORDS  = 256
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus,
    output logic [15:0]   conflict_cnt
);

    localparam int WAIT_CLOG = $clog2(STARVE_LIMIT + 1);
    localparam int WAIT_W    = (WAIT_CLOG > 3) ? WAIT_CLOG : 3;
    // One bit wider than an address so 4*DEPTH_WORDS == 2^32 still compares correctly.
    localparam logic [32:0] ADDR_LIMIT = 33'({32'd0, DEPTH_WORDS} << 2);

    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [15:0]       conflict_q, conflict_d;

    logic        p0_rvalid_q, p1_rvalid_q;
    logic        p0_err_q, p1_err_q;
    logic [31:0] p0_rdata_q, p1_rdata_q;

    logic        gnt0, gnt1;
    logic        p1_starved;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_legal;
    logic [31:0] resp_dat;

    assign p1_starved = (wait_q >= WAIT_W'(STARVE_LIMIT));

    // Grant and selection. Everything is forced idle while rst is high so no
    // memory write can slip through during reset.
    always_comb begin
        gnt1      = 1'b0;
        gnt0      = 1'b0;
        sel_we    = 1'b0;
        sel_addr  = 32'd0;
        sel_wdata = 32'd0;
        if (!rst) begin
            gnt1 = bus.p1_req && (p1_starved || !bus.p0_req);
            gnt0 = bus.p0_req && !gnt1;
        end
        if (gnt1) begin
            sel_we    = bus.p1_we;
            sel_addr  = bus.p1_addr;
            sel_wdata = bus.p1_wdata;
        end else if (gnt0) begin
            sel_we    = bus.p0_we;
            sel_addr  = bus.p0_addr;
            sel_wdata = bus.p0_wdata;
        end
    end

    assign sel_legal = (sel_addr[1:0] == 2'b00) && ({1'b0, sel_addr} < ADDR_LIMIT);
    // Writes and rejected accesses return zero; only a legal read returns memory data.
    assign resp_dat  = (sel_legal && !sel_we) ? bus.mem_rd : 32'd0;

    assign bus.p0_gnt    = gnt0;
    assign bus.p1_gnt    = gnt1;
    assign bus.mem_addr  = sel_addr;
    assign bus.mem_wd    = sel_wdata;
    assign bus.mem_write = (gnt0 || gnt1) && sel_we && sel_legal;

    // Wait counter: runs while port 1 is kept waiting, saturates, clears otherwise.
    always_comb begin
        wait_d = wait_q;
        if (!bus.p1_req || gnt1) begin
            wait_d = '0;
        end else if (wait_q != '1) begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    always_comb begin
        conflict_d = conflict_q;
        if (bus.p0_req && bus.p1_req && (conflict_q != 16'hFFFF)) begin
            conflict_d = conflict_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q      <= '0;
            conflict_q  <= 16'd0;
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
            p0_err_q    <= 1'b0;
            p1_err_q    <= 1'b0;
            p0_rdata_q  <= 32'd0;
            p1_rdata_q  <= 32'd0;
        end else begin
            wait_q      <= wait_d;
            conflict_q  <= conflict_d;
            p0_rvalid_q <= gnt0;
            p1_rvalid_q <= gnt1;
            p0_err_q    <= gnt0 && !sel_legal;
            p1_err_q    <= gnt1 && !sel_legal;
            // rdata of the idle port holds its last response.
            if (gnt0) begin
                p0_rdata_q <= resp_dat;
            end
            if (gnt1) begin
                p1_rdata_q <= resp_dat;
            end
        end
    end

    assign bus.p0_rvalid = p0_rvalid_q;
    assign bus.p1_rvalid = p1_rvalid_q;
    assign bus.p0_err    = p0_err_q;
    assign bus.p1_err    = p1_err_q;
    assign bus.p0_rdata  = p0_rdata_q;
    assign bus.p1_rdata  = p1_rdata_q;
    assign conflict_cnt  = conflict_q;

endmodule
